// File: rtl/avalon_arbiter_if.sv
// avalon_arbiter_if: bundle of two request ports and one shared Avalon-MM slave.
// master: arbiter view (masters the shared slave); slave: environment view.
interface avalon_arbiter_if;
  logic [1:0]  m_read;
  logic [1:0]  m_write;
  logic [63:0] m_address;
  logic [7:0]  m_byteenable;
  logic [63:0] m_writedata;
  logic [63:0] m_readdata;
  logic [1:0]  m_waitrequest;
  logic        s_read;
  logic        s_write;
  logic [31:0] s_address;
  logic [3:0]  s_byteenable;
  logic [31:0] s_writedata;
  logic [31:0] s_readdata;
  logic        s_waitrequest;

  modport master (
    input  m_read,
    input  m_write,
    input  m_address,
    input  m_byteenable,
    input  m_writedata,
    output m_readdata,
    output m_waitrequest,
    output s_read,
    output s_write,
    output s_address,
    output s_byteenable,
    output s_writedata,
    input  s_readdata,
    input  s_waitrequest
  );

  modport slave (
    output m_read,
    output m_write,
    output m_address,
    output m_byteenable,
    output m_writedata,
    input  m_readdata,
    input  m_waitrequest,
    input  s_read,
    input  s_write,
    input  s_address,
    input  s_byteenable,
    input  s_writedata,
    output s_readdata,
    output s_waitrequest
  );
endinterface

// File: rtl/avalon_arbiter.sv
// avalon_arbiter: 2-master (0=ifetch, 1=data) to 1-slave Avalon-MM arbiter.
// Ports: clk, reset_n, bus (masters+slave), grant, timeout_err, proto_err.
module avalon_arbiter #(
  parameter int FAIR           = 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  avalon_arbiter_if.master bus,
  output logic [1:0]       grant,
  output logic             timeout_err,
  output logic             proto_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY0 = 2'b01,
    BUSY1 = 2'b10
  } state_e;

  localparam logic [31:0] TMO      = 32'(TIMEOUT_CYCLES);
  localparam logic [15:0] STALL_MX = 16'hFFFF;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic [15:0] stall_q, stall_d;
  logic        tmo_q, tmo_d;
  logic        perr_q, perr_d;

  logic [1:0]  req;
  logic        busy;
  logic        own;
  logic        own_req;
  logic        done;
  logic        sel_rd;
  logic        sel_wr;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic [3:0]  sel_be;
  state_e      tie_win;

  assign req     = bus.m_read | bus.m_write;
  assign busy    = (state_q != IDLE);
  assign own     = (state_q == BUSY1);
  assign own_req = own ? req[1] : req[0];
  assign done    = busy & ~bus.s_waitrequest;

  // Round-robin hands a tie to whoever was not served last.
  assign tie_win = (FAIR != 0) ?
                   (last_q ? BUSY0 : BUSY1) :
                   BUSY1;

  always_comb begin
    sel_rd    = own ? bus.m_read[1]          : bus.m_read[0];
    sel_wr    = own ? bus.m_write[1]         : bus.m_write[0];
    sel_addr  = own ? bus.m_address[63:32]   : bus.m_address[31:0];
    sel_wdata = own ? bus.m_writedata[63:32] : bus.m_writedata[31:0];
    sel_be    = own ? bus.m_byteenable[7:4]  : bus.m_byteenable[3:0];
  end

  // Read wins when an owner raises both strobes.
  always_comb begin
    bus.s_read       = busy & sel_rd;
    bus.s_write      = busy & sel_wr & ~sel_rd;
    bus.s_address    = busy ? sel_addr  : '0;
    bus.s_byteenable = busy ? sel_be    : '0;
    bus.s_writedata  = busy ? sel_wdata : '0;
  end

  always_comb begin
    grant             = 2'b00;
    bus.m_waitrequest = 2'b11;
    bus.m_readdata    = '0;
    unique case (state_q)
      BUSY0: begin
        grant                = 2'b01;
        bus.m_waitrequest[0] = bus.s_waitrequest;
        bus.m_readdata[31:0] = bus.s_readdata;
      end
      BUSY1: begin
        grant                 = 2'b10;
        bus.m_waitrequest[1]  = bus.s_waitrequest;
        bus.m_readdata[63:32] = bus.s_readdata;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          (req == 2'b11): state_d = tie_win;
          (req == 2'b01): state_d = BUSY0;
          (req == 2'b10): state_d = BUSY1;
          default:        state_d = IDLE;
        endcase
      end
      BUSY0, BUSY1: begin
        // A dropped request abandons the slot without
        // counting as service.
        if (!own_req) begin
          state_d = IDLE;
        end else if (done) begin
          state_d = IDLE;
          last_d  = own;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    stall_d = '0;
    if (busy) begin
      stall_d = stall_q;
      if (bus.s_waitrequest && stall_q != STALL_MX)
        stall_d = stall_q + 16'd1;
    end
    tmo_d  = tmo_q |
             ((TMO != 32'd0) &&
              ({16'd0, stall_d} >= TMO));
    perr_d = perr_q | (busy & sel_rd & sel_wr);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      stall_q <= '0;
      tmo_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      stall_q <= stall_d;
      tmo_q   <= tmo_d;
      perr_q  <= perr_d;
    end
  end

  assign timeout_err = tmo_q;
  assign proto_err   = perr_q;

  a_grant_1h: assert property (
    @(posedge clk) disable iff (!reset_n)
    $onehot0(grant));

  a_rw_excl: assert property (
    @(posedge clk) disable iff (!reset_n)
    !(bus.s_read && bus.s_write));

endmodule

// File: tb/tb_avalon_arbiter.sv
// tb_avalon_arbiter: table, directed and random checks of avalon_arbiter.
// Two instances (round-robin and fixed priority) share one stimulus.
module tb_avalon_arbiter;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  m_read, m_write;
  logic [63:0] m_address, m_writedata;
  logic [7:0]  m_byteenable;
  logic [31:0] s_readdata;
  logic        s_waitrequest;
  logic [1:0]  grant, grant_f;
  logic        tmo, tmo_f, perr, perr_f;

  int n_cmp;
  int n_bad;

  // Reference: owner (-1 idle), last served, stall count, flags.
  int mo[2];
  int ml[2];
  int ms[2];
  bit mt[2];
  bit mp[2];

  typedef struct {
    logic [1:0] rd;
    logic [1:0] wr;
    logic [1:0] g_fair;
    logic [1:0] g_fix;
    logic       sr;
    logic       sw;
  } vec_t;

  always #5 clk = ~clk;

  avalon_arbiter_if bus();
  avalon_arbiter_if busf();

  assign bus.m_read        = m_read;
  assign bus.m_write       = m_write;
  assign bus.m_address     = m_address;
  assign bus.m_byteenable  = m_byteenable;
  assign bus.m_writedata   = m_writedata;
  assign bus.s_readdata    = s_readdata;
  assign bus.s_waitrequest = s_waitrequest;
  assign busf.m_read        = m_read;
  assign busf.m_write       = m_write;
  assign busf.m_address     = m_address;
  assign busf.m_byteenable  = m_byteenable;
  assign busf.m_writedata   = m_writedata;
  assign busf.s_readdata    = s_readdata;
  assign busf.s_waitrequest = s_waitrequest;

  avalon_arbiter #(.FAIR(1), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .grant(grant), .timeout_err(tmo), .proto_err(perr));

  avalon_arbiter #(.FAIR(0), .TIMEOUT_CYCLES(TO)) dut_fix (
    .clk(clk), .reset_n(reset_n), .bus(busf),
    .grant(grant_f), .timeout_err(tmo_f), .proto_err(perr_f));

  function automatic bit rq(int k);
    return m_read[k] | m_write[k];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mo[i] = -1;
      ml[i] = 1;
      ms[i] = 0;
      mt[i] = 1'b0;
      mp[i] = 1'b0;
    end
  endtask

  // Instance 0 is round-robin, instance 1 favours master 1.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      int k;
      k = mo[i];
      if (k < 0) begin
        ms[i] = 0;
        if (rq(0) && rq(1))
          mo[i] = (i == 0) ? 1 - ml[i] : 1;
        else if (rq(0))
          mo[i] = 0;
        else if (rq(1))
          mo[i] = 1;
        else
          mo[i] = -1;
      end else begin
        if (s_waitrequest && ms[i] < 65535)
          ms[i] = ms[i] + 1;
        if (ms[i] >= TO)
          mt[i] = 1'b1;
        if (m_read[k] && m_write[k])
          mp[i] = 1'b1;
        if (!rq(k)) begin
          mo[i] = -1;
        end else if (!s_waitrequest) begin
          ml[i] = k;
          mo[i] = -1;
        end
      end
    end
  endtask

  function automatic logic [139:0] exp_vec(int i);
    logic [1:0]  g;
    logic        sr, sw;
    logic [31:0] sa, swd;
    logic [3:0]  sbe;
    logic [1:0]  mw;
    logic [63:0] mrd;
    int k;
    k   = mo[i];
    g   = 2'b00;
    sr  = 1'b0;
    sw  = 1'b0;
    sa  = '0;
    swd = '0;
    sbe = '0;
    mw  = 2'b11;
    mrd = '0;
    if (k >= 0) begin
      g[k] = 1'b1;
      sr   = m_read[k];
      sw   = m_write[k] & ~m_read[k];
      sa   = m_address[32*k +: 32];
      swd  = m_writedata[32*k +: 32];
      sbe  = m_byteenable[4*k +: 4];
      mrd[32*k +: 32] = s_readdata;
      if (!s_waitrequest) mw[k] = 1'b0;
    end
    return {g, sr, sw, sa, sbe, swd, mw, mrd, mt[i], mp[i]};
  endfunction

  function automatic logic [139:0] act_vec(int i);
    if (i == 0)
      return {grant, bus.s_read, bus.s_write,
              bus.s_address, bus.s_byteenable,
              bus.s_writedata, bus.m_waitrequest,
              bus.m_readdata, tmo, perr};
    return {grant_f, busf.s_read, busf.s_write,
            busf.s_address, busf.s_byteenable,
            busf.s_writedata, busf.m_waitrequest,
            busf.m_readdata, tmo_f, perr_f};
  endfunction

  task automatic cmp(input string name,
                     input logic [139:0] act,
                     input logic [139:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h",
               name, act, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    cmp("model_fair", act_vec(0), exp_vec(0));
    cmp("model_fix", act_vec(1), exp_vec(1));
  endtask

  task automatic tick();
    @(posedge clk);
    if (reset_n) model_edge();
    #1;
  endtask

  task automatic step();
    sample();
    tick();
  endtask

  task automatic rst_pulse();
    reset_n       = 1'b0;
    model_reset();
    m_read        = 2'b00;
    m_write       = 2'b00;
    s_waitrequest = 1'b0;
    sample();
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tbl[9];
    logic [1:0] g39[8];
    logic       seen;

    tbl[0] = '{2'b01, 2'b00, 2'b01, 2'b01, 1'b1, 1'b0};
    tbl[1] = '{2'b10, 2'b00, 2'b10, 2'b10, 1'b1, 1'b0};
    tbl[2] = '{2'b00, 2'b01, 2'b01, 2'b01, 1'b0, 1'b1};
    tbl[3] = '{2'b00, 2'b10, 2'b10, 2'b10, 1'b0, 1'b1};
    tbl[4] = '{2'b11, 2'b00, 2'b01, 2'b10, 1'b1, 1'b0};
    tbl[5] = '{2'b00, 2'b11, 2'b01, 2'b10, 1'b0, 1'b1};
    tbl[6] = '{2'b01, 2'b01, 2'b01, 2'b01, 1'b1, 1'b0};
    tbl[7] = '{2'b10, 2'b01, 2'b01, 2'b10, 1'b0, 1'b1};
    tbl[8] = '{2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
    g39[0] = 2'b00; g39[1] = 2'b01;
    g39[2] = 2'b00; g39[3] = 2'b10;
    g39[4] = 2'b00; g39[5] = 2'b01;
    g39[6] = 2'b00; g39[7] = 2'b10;

    n_cmp         = 0;
    n_bad         = 0;
    reset_n       = 1'b0;
    m_read        = 2'b00;
    m_write       = 2'b00;
    m_address     = '0;
    m_writedata   = '0;
    m_byteenable  = '0;
    s_readdata    = '0;
    s_waitrequest = 1'b0;
    model_reset();

    // reset state
    sample();
    cmp("rst_grant", grant, 2'b00);
    cmp("rst_mwait", bus.m_waitrequest, 2'b11);
    cmp("rst_mrdata", bus.m_readdata, 64'd0);
    cmp("rst_strobes", {bus.s_read, bus.s_write}, 2'b00);
    cmp("rst_flags", {tmo, perr}, 2'b00);
    tick();
    reset_n = 1'b1;

    // single-arbitration table
    m_address    = 64'h2222_0040_1111_0080;
    m_writedata  = 64'hCAFE_0002_BEEF_0001;
    m_byteenable = 8'hC3;
    s_readdata   = 32'h0BAD_F00D;
    for (int i = 0; i < 9; i++) begin
      rst_pulse();
      m_read        = tbl[i].rd;
      m_write       = tbl[i].wr;
      s_waitrequest = 1'b1;
      step();
      sample();
      cmp($sformatf("tbl%0d_gfair", i), grant, tbl[i].g_fair);
      cmp($sformatf("tbl%0d_gfix", i), grant_f, tbl[i].g_fix);
      cmp($sformatf("tbl%0d_strobe", i),
          {bus.s_read, bus.s_write}, {tbl[i].sr, tbl[i].sw});
      tick();
      m_read        = 2'b00;
      m_write       = 2'b00;
      s_waitrequest = 1'b0;
      step();
      step();
    end

    // master 0 boot read with two stall cycles
    rst_pulse();
    m_address     = 64'h0;
    m_address[31:0] = 32'hBFC0_0000;
    s_readdata    = 32'h1234_5678;
    m_read        = 2'b01;
    s_waitrequest = 1'b1;
    step();
    sample();
    cmp("b038_busy", {grant, bus.s_read, bus.s_address},
        {2'b01, 1'b1, 32'hBFC0_0000});
    tick();
    step();
    s_waitrequest = 1'b0;
    sample();
    cmp("b038_done", {bus.m_waitrequest, bus.m_readdata[31:0]},
        {2'b10, 32'h1234_5678});
    tick();
    m_read        = 2'b00;
    s_waitrequest = 1'b1;
    sample();
    cmp("b038_idle", grant, 2'b00);
    tick();

    // round-robin alternation
    rst_pulse();
    m_read        = 2'b11;
    s_waitrequest = 1'b0;
    for (int c = 0; c < 8; c++) begin
      sample();
      cmp($sformatf("rr_c%0d", c), grant, g39[c]);
      tick();
    end
    m_read = 2'b00;
    step();
    step();

    // fixed priority starves master 0 while master 1 asks
    rst_pulse();
    m_read        = 2'b11;
    s_waitrequest = 1'b0;
    for (int c = 0; c < 8; c++) begin
      sample();
      cmp($sformatf("fix_c%0d", c), grant_f,
          (c % 2 == 1) ? 2'b10 : 2'b00);
      tick();
    end
    m_read = 2'b01;
    seen   = 1'b0;
    for (int c = 0; c < 4; c++) begin
      sample();
      if (grant_f == 2'b01) seen = 1'b1;
      tick();
    end
    cmp("fix_m0_served", seen, 1'b1);
    m_read = 2'b00;
    step();
    step();

    // long stall on a master 1 write
    rst_pulse();
    m_address     = 64'h0000_1000_0000_0000;
    m_writedata   = 64'hDEAD_BEEF_0000_0000;
    m_byteenable  = 8'b0011_0000;
    m_write       = 2'b10;
    s_waitrequest = 1'b1;
    step();
    for (int j = 1; j <= 70; j++) begin
      sample();
      cmp($sformatf("stall_hold_%0d", j),
          {bus.s_writedata, bus.s_byteenable},
          {32'hDEAD_BEEF, 4'b0011});
      cmp($sformatf("stall_tmo_%0d", j), tmo, (j - 1) >= TO);
      tick();
    end
    s_waitrequest = 1'b0;
    sample();
    cmp("stall_done", {grant, bus.m_waitrequest, bus.s_write, tmo},
        {2'b10, 2'b01, 1'b1, 1'b1});
    tick();
    m_write = 2'b00;
    sample();
    cmp("stall_sticky", {grant, tmo}, {2'b00, 1'b1});
    tick();

    // reset in the middle of a master 0 transfer
    rst_pulse();
    m_address     = 64'h0000_2000_0000_3000;
    m_read        = 2'b01;
    s_waitrequest = 1'b0;
    step();
    step();
    step();
    s_waitrequest = 1'b1;
    sample();
    cmp("mid_busy", {grant, bus.s_read}, {2'b01, 1'b1});
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    cmp("mid_rst", {grant, bus.s_read, bus.m_waitrequest},
        {2'b00, 1'b0, 2'b11});
    tick();
    reset_n       = 1'b1;
    m_read        = 2'b11;
    s_waitrequest = 1'b0;
    step();
    sample();
    cmp("mid_tie_m0", grant, 2'b01);
    tick();
    m_read = 2'b00;
    step();
    step();

    // read and write together from master 0
    rst_pulse();
    m_read        = 2'b01;
    m_write       = 2'b01;
    s_waitrequest = 1'b1;
    step();
    sample();
    cmp("rw_strobe", {bus.s_read, bus.s_write, perr},
        {1'b1, 1'b0, 1'b0});
    tick();
    sample();
    cmp("rw_perr", perr, 1'b1);
    tick();
    s_waitrequest = 1'b0;
    step();
    m_read  = 2'b00;
    m_write = 2'b00;
    step();
    sample();
    cmp("rw_sticky", perr, 1'b1);
    tick();
    rst_pulse();
    sample();
    cmp("rw_cleared", perr, 1'b0);
    tick();

    // random traffic against the reference
    for (int n = 0; n < 3000; n++) begin
      for (int k = 0; k < 2; k++) begin
        int r;
        r = $urandom_range(0, 9);
        m_read[k]  = (r >= 4 && r <= 6) || r == 9;
        m_write[k] = (r == 7 || r == 8 || r == 9);
      end
      m_address     = {$urandom, $urandom};
      m_writedata   = {$urandom, $urandom};
      m_byteenable  = 8'($urandom);
      s_readdata    = $urandom;
      s_waitrequest = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 149) == 0) begin
        reset_n = 1'b0;
        model_reset();
      end else begin
        reset_n = 1'b1;
      end
      step();
    end
    reset_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
